wb_ext_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one external Wishbone B3 slave among NUM_PORTS bus masters. It typically sits between the per-tile `wb_ext_*` ports of a compute-tile system and a single off-chip or simulation memory/peripheral model. Each master's entire bus cycle (`cyc` high, including burst sequences) gets exclusive access. An optional watchdog terminates unanswered transfers with an error.

---
 rtl/wb_ext_rr_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_wb_ext_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ext_rr_arbiter.sv
// Round-robin arbiter sharing one external Wishbone B3 slave among NUM_PORTS masters.
// Optional slave watchdog enabled by defining WB_EXT_ARB_WATCHDOG_EN.
module wb_ext_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int AW        = 32,
`ifdef WB_EXT_ARB_WATCHDOG_EN
    parameter int TIMEOUT   = 255,
`endif
    parameter int DW        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS*AW-1:0]   m_adr_i,
    input  logic [NUM_PORTS*DW-1:0]   m_dat_i,
    input  logic [NUM_PORTS*DW/8-1:0] m_sel_i,
    input  logic [NUM_PORTS-1:0]      m_cyc_i,
    input  logic [NUM_PORTS-1:0]      m_stb_i,
    input  logic [NUM_PORTS-1:0]      m_we_i,
    input  logic [NUM_PORTS-1:0]      m_cab_i,
    input  logic [NUM_PORTS*3-1:0]    m_cti_i,
    input  logic [NUM_PORTS*2-1:0]    m_bte_i,
    output logic [NUM_PORTS*DW-1:0]   m_dat_o,
    output logic [NUM_PORTS-1:0]      m_ack_o,
    output logic [NUM_PORTS-1:0]      m_err_o,
    output logic [NUM_PORTS-1:0]      m_rty_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic                      s_cab_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [NUM_PORTS-1:0]      grant_o
);

    localparam int          SW = DW / 8;
    localparam int          PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned NP = NUM_PORTS;

`ifdef WB_EXT_ARB_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;

    logic                 found;
    logic [PW-1:0]        win;
    logic [PW-1:0]        idx;
    logic [NUM_PORTS-1:0] win_oh;

    logic [AW-1:0]        g_adr;
    logic [DW-1:0]        g_dat;
    logic [SW-1:0]        g_sel;
    logic [2:0]           g_cti;
    logic [1:0]           g_bte;
    logic                 g_cyc, g_stb, g_we, g_cab;

    logic                 busy;
    logic                 timeout;

    assign busy    = (state_q == BUSY);
    assign grant_o = grant_q;
    assign m_dat_o = {NUM_PORTS{s_dat_i}};

    // First requester at or after ptr, searching upward with wrap-around.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = '0;
        win_oh = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            idx = PW'((32'(ptr_q) + i) % NP);
            if (!found && m_cyc_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_oh[win] = found;
    end

    // One-hot AND-OR selection of the owning master's request.
    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_cti = '0;
        g_bte = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (grant_q[p]) begin
                g_adr = g_adr | m_adr_i[p*AW +: AW];
                g_dat = g_dat | m_dat_i[p*DW +: DW];
                g_sel = g_sel | m_sel_i[p*SW +: SW];
                g_cti = g_cti | m_cti_i[p*3 +: 3];
                g_bte = g_bte | m_bte_i[p*2 +: 2];
            end
        end
        g_cyc = |(m_cyc_i & grant_q);
        g_stb = |(m_stb_i & grant_q);
        g_we  = |(m_we_i  & grant_q);
        g_cab = |(m_cab_i & grant_q);
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_cab_o = 1'b0;
        if (busy) begin
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
            s_cti_o = g_cti;
            s_bte_o = g_bte;
            s_cyc_o = g_cyc;
            s_stb_o = g_stb;
            s_we_o  = g_we;
            s_cab_o = g_cab;
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            if (timeout || s_err_i) m_err_o = grant_q;
            if (!timeout && s_ack_i) m_ack_o = grant_q;
            if (!timeout && s_rty_i) m_rty_o = grant_q;
        end
    end

`ifdef WB_EXT_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    assign timeout = busy && (wd_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (busy && s_stb_o && !(s_ack_i || s_err_i || s_rty_i) && !timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = win_oh;
                    ptr_d   = (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
`ifdef WB_EXT_ARB_WATCHDOG_EN
                else if (timeout) begin
                    state_d = ABORT;
                end
`endif
            end
`ifdef WB_EXT_ARB_WATCHDOG_EN
            ABORT: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_ext_rr_arbiter.sv
// Randomized bench for wb_ext_rr_arbiter against an ownership-level reference model.
module tb_wb_ext_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef WB_EXT_ARB_WATCHDOG_EN
    localparam int TMO = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*SW-1:0]   m_sel_i;
    logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i, m_cab_i;
    logic [N*3-1:0]    m_cti_i;
    logic [N*2-1:0]    m_bte_i;
    logic [N*DW-1:0]   m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_cyc_o, s_stb_o, s_we_o, s_cab_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]      grant_o;

    logic [AW-1:0] adr [N];
    logic [DW-1:0] dat [N];
    logic [SW-1:0] sel [N];
    logic [2:0]    cti [N];
    logic [1:0]    bte [N];

    always_comb begin
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        m_cti_i = '0;
        m_bte_i = '0;
        for (int p = 0; p < N; p++) begin
            m_adr_i[p*AW +: AW] = adr[p];
            m_dat_i[p*DW +: DW] = dat[p];
            m_sel_i[p*SW +: SW] = sel[p];
            m_cti_i[p*3 +: 3]   = cti[p];
            m_bte_i[p*2 +: 2]   = bte[p];
        end
    end

    wb_ext_rr_arbiter #(
        .NUM_PORTS(N),
        .AW(AW),
`ifdef WB_EXT_ARB_WATCHDOG_EN
        .TIMEOUT(TMO),
`endif
        .DW(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_cab_i(m_cab_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owning port index (-1 when nobody owns the slave).
    int owner   = -1;
    int rr      = 0;
    int wd      = 0;
    bit aborted = 1'b0;

    bit seen_resp [N];
    bit seen_err  [N];
    bit seen_gnt  [N];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        logic [N-1:0] g_exp, ack_exp, err_exp, rty_exp;
        logic         busy, tmo;
        logic [AW-1:0] adr_e;
        logic [DW-1:0] dat_e;
        logic [14:0]   ctl_e;
        logic [1:0]    cs_e;
        busy    = (owner >= 0) && !aborted;
        tmo     = 1'b0;
`ifdef WB_EXT_ARB_WATCHDOG_EN
        tmo     = busy && (wd == TMO);
`endif
        g_exp   = (owner >= 0) ? (N'(1) << owner) : '0;
        ack_exp = '0;
        err_exp = '0;
        rty_exp = '0;
        adr_e   = '0;
        dat_e   = '0;
        ctl_e   = '0;
        cs_e    = '0;
        if (busy) begin
            adr_e = adr[owner];
            dat_e = dat[owner];
            ctl_e = {m_we_i[owner], m_cab_i[owner], cti[owner], bte[owner], sel[owner], 4'b0};
            cs_e  = {m_cyc_i[owner], m_stb_i[owner]};
            if (tmo || s_err_i)   err_exp = g_exp;
            if (!tmo && s_ack_i)  ack_exp = g_exp;
            if (!tmo && s_rty_i)  rty_exp = g_exp;
        end
        check("grant",   128'(grant_o), 128'(g_exp));
        check("s_cycstb", 128'({s_cyc_o, s_stb_o}), 128'(cs_e));
        check("s_adr",   128'(s_adr_o), 128'(adr_e));
        check("s_dat",   128'(s_dat_o), 128'(dat_e));
        check("s_ctl",   128'({s_we_o, s_cab_o, s_cti_o, s_bte_o, s_sel_o, 4'b0}), 128'(ctl_e));
        check("m_ack",   128'(m_ack_o), 128'(ack_exp));
        check("m_err",   128'(m_err_o), 128'(err_exp));
        check("m_rty",   128'(m_rty_o), 128'(rty_exp));
        check("m_dat",   128'(m_dat_o), 128'({N{s_dat_i}}));
        for (int p = 0; p < N; p++) begin
            seen_resp[p] = m_ack_o[p] | m_err_o[p] | m_rty_o[p];
            seen_err[p]  = m_err_o[p];
            seen_gnt[p]  = grant_o[p];
        end
    endtask

    task automatic model_step();
        if (rst) begin
            owner = -1; rr = 0; wd = 0; aborted = 1'b0;
        end else if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (m_cyc_i[c]) begin
                    owner = c;
                    rr    = (c + 1) % N;
                    break;
                end
            end
        end else if (!m_cyc_i[owner]) begin
            owner = -1; wd = 0; aborted = 1'b0;
        end
`ifdef WB_EXT_ARB_WATCHDOG_EN
        else if (!aborted) begin
            if (wd == TMO) begin
                aborted = 1'b1;
                wd      = 0;
            end else if (m_stb_i[owner] && !(s_ack_i || s_err_i || s_rty_i)) begin
                wd++;
            end else begin
                wd = 0;
            end
        end
`endif
    endtask

    task automatic new_beat(input int p);
        adr[p]     = $urandom;
        dat[p]     = $urandom;
        sel[p]     = SW'($urandom);
        cti[p]     = 3'($urandom);
        bte[p]     = 2'($urandom);
        m_we_i[p]  = 1'($urandom);
        m_cab_i[p] = 1'($urandom);
    endtask

    task automatic drop(input int p);
        m_cyc_i[p] = 1'b0;
        m_stb_i[p] = 1'b0;
    endtask

    task automatic drive(input int req_pct, input int resp_pct, input int rst_pct);
        int r;
        rst = ($urandom_range(99) < rst_pct);
        for (int p = 0; p < N; p++) begin
            if (!m_cyc_i[p]) begin
                if ($urandom_range(99) < req_pct) begin
                    m_cyc_i[p] = 1'b1;
                    m_stb_i[p] = 1'b1;
                    new_beat(p);
                end
            end else if (seen_err[p]) begin
                drop(p);
            end else if (seen_resp[p]) begin
                if ($urandom_range(1) == 0) drop(p);
                else new_beat(p);
            end else if (!seen_gnt[p] && $urandom_range(99) < 5) begin
                drop(p);
            end
        end
        s_dat_i = $urandom;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
        if ($urandom_range(99) < resp_pct) begin
            r = $urandom_range(9);
            if (r < 8)       s_ack_i = 1'b1;
            else if (r == 8) s_err_i = 1'b1;
            else             s_rty_i = 1'b1;
        end
    endtask

    task automatic run(input int cycles, input int req_pct, input int resp_pct, input int rst_pct);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            model_step();
            #1;
            drive(req_pct, resp_pct, rst_pct);
        end
    endtask

    initial begin
        rst     = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_cab_i = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
        for (int p = 0; p < N; p++) begin
            adr[p] = '0; dat[p] = '0; sel[p] = '0; cti[p] = '0; bte[p] = '0;
            seen_resp[p] = 1'b0; seen_err[p] = 1'b0; seen_gnt[p] = 1'b0;
        end
        run(3, 0, 50, 100);
        run(1500, 30, 60, 0);
        run(60, 70, 0, 0);
        run(1500, 40, 50, 1);
        run(30, 0, 60, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
